// File: rtl/axil2native_adapter_pkg.sv
// rtl/axil2native_adapter_pkg.sv - shared FSM encoding and AXI response codes
// Contents: state_e (IDLE/WR/RD/BRESP/RRESP, 3-bit), RESP_OKAY, RESP_SLVERR.
package axil2native_adapter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_BRESP = 3'd3,
    ST_RRESP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil2native_adapter.sv
// rtl/axil2native_adapter.sv - AXI4-lite slave to native-interface master bridge
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w*   write address / data channels, one-deep buffers each
//   s_axi_b*               write response, always OKAY
//   s_axi_ar*              read address channel, arprot[2] = instruction fetch
//   s_axi_r*               read data / response, always OKAY
//   native_*               single outstanding native request; native_ready is a
//                          one-cycle completion pulse, native_wstrb == 0 means read
module axil2native_adapter
  import axil2native_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  native_valid,
  output logic                  native_instr,
  input  logic                  native_ready,
  output logic [ADDR_WIDTH-1:0] native_addr,
  output logic [DATA_WIDTH-1:0] native_wdata,
  output logic [STRB_WIDTH-1:0] native_wstrb,
  input  logic [DATA_WIDTH-1:0] native_rdata
);

  state_e                state_q;
  // Low while in reset so every ready output is 0 during reset, not just the state.
  logic                  run_q;

  logic                  aw_full_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  w_full_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  ar_full_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic                  ar_instr_q;

  // Set after a read is served, cleared after a write: under contention the
  // type not served last wins, and the reset value makes read go first.
  logic                  prio_write_q;

  logic                  native_valid_q;
  logic                  native_instr_q;
  logic [ADDR_WIDTH-1:0] native_addr_q;
  logic [DATA_WIDTH-1:0] native_wdata_q;
  logic [STRB_WIDTH-1:0] native_wstrb_q;
  logic                  bvalid_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic wr_pend;
  logic rd_pend;
  logic unused_prot;

  assign s_axi_awready = run_q & ~aw_full_q;
  assign s_axi_wready  = run_q & ~w_full_q;
  assign s_axi_arready = run_q & ~ar_full_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  assign wr_pend = aw_full_q & w_full_q;
  assign rd_pend = ar_full_q;

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = RESP_OKAY;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = RESP_OKAY;

  assign native_valid = native_valid_q;
  assign native_instr = native_instr_q;
  assign native_addr  = native_addr_q;
  assign native_wdata = native_wdata_q;
  assign native_wstrb = native_wstrb_q;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      run_q          <= 1'b0;
      aw_full_q      <= 1'b0;
      aw_addr_q      <= '0;
      w_full_q       <= 1'b0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      ar_full_q      <= 1'b0;
      ar_addr_q      <= '0;
      ar_instr_q     <= 1'b0;
      prio_write_q   <= 1'b0;
      native_valid_q <= 1'b0;
      native_instr_q <= 1'b0;
      native_addr_q  <= '0;
      native_wdata_q <= '0;
      native_wstrb_q <= '0;
      bvalid_q       <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
    end else begin
      run_q <= 1'b1;

      // Buffers only load while empty, so these never collide with the
      // clears below (a buffer is full for the whole time it is being served).
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (ar_hs) begin
        ar_full_q  <= 1'b1;
        ar_addr_q  <= s_axi_araddr;
        ar_instr_q <= s_axi_arprot[2];
      end

      case (state_q)
        ST_IDLE: begin
          if (wr_pend && (!rd_pend || prio_write_q)) begin
            prio_write_q <= 1'b0;
            if (w_strb_q == '0) begin
              // Nothing to write: answer immediately without a native access.
              state_q   <= ST_BRESP;
              bvalid_q  <= 1'b1;
              aw_full_q <= 1'b0;
              w_full_q  <= 1'b0;
            end else begin
              state_q        <= ST_WR;
              native_valid_q <= 1'b1;
              native_instr_q <= 1'b0;
              native_addr_q  <= aw_addr_q;
              native_wdata_q <= w_data_q;
              native_wstrb_q <= w_strb_q;
            end
          end else if (rd_pend) begin
            prio_write_q   <= 1'b1;
            state_q        <= ST_RD;
            native_valid_q <= 1'b1;
            native_instr_q <= ar_instr_q;
            native_addr_q  <= ar_addr_q;
            native_wstrb_q <= '0;
          end
        end
        ST_WR: begin
          if (native_ready) begin
            native_valid_q <= 1'b0;
            state_q        <= ST_BRESP;
            bvalid_q       <= 1'b1;
            aw_full_q      <= 1'b0;
            w_full_q       <= 1'b0;
          end
        end
        ST_RD: begin
          if (native_ready) begin
            native_valid_q <= 1'b0;
            state_q        <= ST_RRESP;
            rvalid_q       <= 1'b1;
            rdata_q        <= native_rdata;
            ar_full_q      <= 1'b0;
          end
        end
        ST_BRESP: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_RRESP: begin
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil2native_adapter.sv
// tb/tb_axil2native_adapter.sv - self-checking bench for axil2native_adapter
module tb_axil2native_adapter;

  logic        clk;
  logic        resetn;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        native_valid, native_instr, native_ready;
  logic [31:0] native_addr, native_wdata, native_rdata;
  logic [3:0]  native_wstrb;

  bit          auto_mode;
  logic        auto_ready, man_ready;
  logic [31:0] auto_rdata, man_rdata;

  assign native_ready = auto_mode ? auto_ready : man_ready;
  assign native_rdata = auto_mode ? auto_rdata : man_rdata;

  int checks;
  int errors;

  typedef struct {
    logic        is_wr;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } nreq_t;
  nreq_t log_q[$];

  axil2native_adapter dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .native_valid(native_valid), .native_instr(native_instr), .native_ready(native_ready),
    .native_addr(native_addr), .native_wdata(native_wdata), .native_wstrb(native_wstrb),
    .native_rdata(native_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Peripheral data source: what the native slave returns for an address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Auto-responding native slave: random wait states, logs every completed
  // request, and throws stray ready pulses while no request is active.
  initial begin : periph
    int    wait_cnt;
    nreq_t e;
    auto_ready = 1'b0;
    auto_rdata = '0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      auto_ready = 1'b0;
      if (auto_mode && resetn && native_valid) begin
        if (wait_cnt == 0) begin
          auto_ready = 1'b1;
          auto_rdata = rd_fn(native_addr);
          e.is_wr = (native_wstrb != 4'h0);
          e.instr = native_instr;
          e.addr  = native_addr;
          e.wdata = native_wdata;
          e.wstrb = native_wstrb;
          log_q.push_back(e);
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end else if (auto_mode && $urandom_range(0, 3) == 0) begin
        auto_ready = 1'b1;
        auto_rdata = $urandom;
      end
    end
  end

  task automatic aw_send(input logic [31:0] a);
    logic hs;
    hs = 1'b0;
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = a;
    for (int n = 0; n < 200 && !hs; n++) begin
      hs = s_axi_awready;
      @(negedge clk);
    end
    s_axi_awvalid = 1'b0;
    check("aw_accept", hs, 1'b1);
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    logic hs;
    hs = 1'b0;
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    for (int n = 0; n < 200 && !hs; n++) begin
      hs = s_axi_wready;
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0;
    check("w_accept", hs, 1'b1);
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [2:0] p);
    logic hs;
    hs = 1'b0;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = a;
    s_axi_arprot  = p;
    for (int n = 0; n < 200 && !hs; n++) begin
      hs = s_axi_arready;
      @(negedge clk);
    end
    s_axi_arvalid = 1'b0;
    check("ar_accept", hs, 1'b1);
  endtask

  task automatic b_recv(input int dly);
    int n;
    n = 0;
    while (!s_axi_bvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_valid", s_axi_bvalid, 1'b1);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("b_hold", s_axi_bvalid, 1'b1);
    end
    check("b_resp", s_axi_bresp, 2'b00);
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic r_recv(input logic [31:0] exp, input int dly);
    int n;
    n = 0;
    while (!s_axi_rvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("r_valid", s_axi_rvalid, 1'b1);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("r_hold", {s_axi_rvalid, s_axi_rdata}, {1'b1, exp});
    end
    check("r_data", {s_axi_rresp, s_axi_rdata}, {2'b00, exp});
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int skew, input int bdly);
    nreq_t e;
    fork
      begin
        repeat (skew > 0 ? skew : 0) @(negedge clk);
        aw_send(a);
      end
      begin
        repeat (skew < 0 ? -skew : 0) @(negedge clk);
        w_send(d, s);
      end
    join
    b_recv(bdly);
    check("wr_native_cnt", log_q.size(), (s == 4'h0) ? 0 : 1);
    if (s != 4'h0 && log_q.size() != 0) begin
      e = log_q.pop_front();
      check("wr_naddr", e.addr, a);
      check("wr_nwdata", {e.instr, e.wstrb, e.wdata}, {1'b0, s, d});
    end
    log_q.delete();
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [2:0] p, input int rdly);
    nreq_t e;
    ar_send(a, p);
    r_recv(rd_fn(a), rdly);
    check("rd_native_cnt", log_q.size(), 1);
    if (log_q.size() != 0) begin
      e = log_q.pop_front();
      check("rd_naddr", e.addr, a);
      check("rd_nkind", {e.wstrb, e.instr}, {4'h0, p[2]});
    end
    log_q.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                       s_axi_rvalid, native_valid, native_instr}, 7'b0);
    check("rst_regs", {native_addr, native_wstrb, s_axi_rdata}, 68'h0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
  endtask

  initial begin
    int nv_seen;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    auto_mode = 1'b0;
    man_ready = 1'b0;
    man_rdata = '0;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awprot = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_bready = 0;
    s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arprot = '0;
    s_axi_rready = 0;

    do_reset();

    // Single write, AW and W in the same cycle, manual native slave.
    s_axi_awvalid = 1; s_axi_awaddr = 32'h10;
    s_axi_wvalid = 1; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF;
    @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    check("wr_lat_buf", native_valid, 1'b0);
    @(negedge clk);
    check("wr_nv", native_valid, 1'b1);
    check("wr_fields", {native_instr, native_wstrb, native_addr, native_wdata},
          {1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF});
    repeat (2) begin
      @(negedge clk);
      check("wr_stable", {native_valid, native_addr, native_wdata}, {1'b1, 32'h10, 32'hDEAD_BEEF});
    end
    man_ready = 1;
    @(negedge clk);
    man_ready = 0;
    check("wr_bvalid", {s_axi_bvalid, native_valid, s_axi_bresp}, {1'b1, 1'b0, 2'b00});
    s_axi_bready = 1;
    @(negedge clk);
    s_axi_bready = 0;
    check("wr_bdone", s_axi_bvalid, 1'b0);

    // Single instruction-fetch read with a stalled R channel.
    s_axi_arvalid = 1; s_axi_araddr = 32'h20; s_axi_arprot = 3'b100;
    @(negedge clk);
    s_axi_arvalid = 0;
    @(negedge clk);
    check("rd_fields", {native_valid, native_instr, native_wstrb, native_addr},
          {1'b1, 1'b1, 4'h0, 32'h20});
    man_rdata = 32'h1234_5678; man_ready = 1;
    @(negedge clk);
    man_ready = 0; man_rdata = '0;
    check("rd_rvalid", {s_axi_rvalid, s_axi_rdata, s_axi_rresp}, {1'b1, 32'h1234_5678, 2'b00});
    repeat (3) begin
      @(negedge clk);
      check("rd_rhold", {s_axi_rvalid, s_axi_rdata}, {1'b1, 32'h1234_5678});
    end
    s_axi_rready = 1;
    @(negedge clk);
    s_axi_rready = 0;
    check("rd_rdone", s_axi_rvalid, 1'b0);

    // W three cycles ahead of AW: nothing goes out until the address arrives.
    w_send(32'hCAFE_F00D, 4'h3);
    nv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      nv_seen += native_valid;
    end
    check("w_early_idle", nv_seen, 0);
    aw_send(32'h44);
    for (int n = 0; n < 10 && !native_valid; n++) @(negedge clk);
    check("w_early_req", {native_valid, native_addr, native_wdata, native_wstrb},
          {1'b1, 32'h44, 32'hCAFE_F00D, 4'h3});
    man_ready = 1;
    @(negedge clk);
    man_ready = 0;
    b_recv(0);

    // Zero strobe write: response without any native access.
    s_axi_awvalid = 1; s_axi_awaddr = 32'h50;
    s_axi_wvalid = 1; s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'h0;
    @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    check("wz_idle", {s_axi_bvalid, native_valid}, 2'b00);
    @(negedge clk);
    check("wz_bvalid", {s_axi_bvalid, native_valid}, 2'b10);
    s_axi_bready = 1;
    @(negedge clk);
    s_axi_bready = 0;
    check("wz_bdone", s_axi_bvalid, 1'b0);

    // Reset pulsed while a read is waiting on the native side.
    ar_send(32'h30, 3'b000);
    for (int n = 0; n < 10 && !native_valid; n++) @(negedge clk);
    check("rst_mid_nv", native_valid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("rst_async", {native_valid, s_axi_rvalid, s_axi_bvalid, s_axi_awready,
                        s_axi_wready, s_axi_arready}, 6'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    auto_mode = 1'b1;
    log_q.delete();
    read_txn(32'h40, 3'b100, 1);

    // Continuous contention straight after reset: read first, then alternate.
    auto_mode = 1'b0;
    do_reset();
    auto_mode = 1'b1;
    log_q.delete();
    s_axi_bready = 1; s_axi_rready = 1;
    fork
      for (int i = 0; i < 3; i++) ar_send(32'h100 + i * 4, 3'b000);
      for (int i = 0; i < 3; i++) begin
        fork
          aw_send(32'h200 + i * 4);
          w_send(32'hA0 + i, 4'hF);
        join
      end
    join
    for (int n = 0; n < 400 && log_q.size() < 6; n++) @(negedge clk);
    check("rr_count", log_q.size(), 6);
    for (int i = 0; i < log_q.size(); i++) begin
      check("rr_order", log_q[i].is_wr, (i % 2));
      check("rr_addr", log_q[i].addr, ((i % 2) ? 32'h200 : 32'h100) + (i / 2) * 4);
    end
    repeat (4) @(negedge clk);
    check("rr_drained", {s_axi_bvalid, s_axi_rvalid, native_valid}, 3'b000);
    s_axi_bready = 0; s_axi_rready = 0;
    log_q.delete();

    // Randomized single transactions against the reference expectations.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] a, d;
        logic [3:0]  s;
        a = $urandom & 32'hFFFF_FFFC;
        d = $urandom;
        s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        write_txn(a, d, s, $urandom_range(0, 6) - 3, $urandom_range(0, 3));
      end else begin
        read_txn($urandom & 32'hFFFF_FFFC, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
